// File: rtl/background_scroller.sv
// background_scroller
// Address generation and pixel fetch for the scrolling background layer.
// For each pixel, the draw coordinate plus the frame scroll offset becomes a
// background ROM address. The colour index that the ROM returns is then
// registered out to the palette stage.
// Latency from DrawX/DrawY/blank_n to index is a fixed 3 cycles:
//   stage 1 registers rom_addr and the force-blank flag,
//   stage 2 is the synchronous ROM read, with the force flag delayed alongside it,
//   stage 3 registers index.
// The scroll state machine has three states (IDLE, RUN, FREEZE). Its state is
// exposed directly on the state output.
module background_scroller #(
  parameter int BG_W_LOG2 = 8,
  parameter int BG_H      = 240,
  parameter int SHIFT     = 1,
  parameter int ADDR_W    = 16,
  parameter int BLANK_IDX = 6
) (
  input  logic                       Clk,
  input  logic                       Reset_n,
  input  logic [9:0]                 DrawX,
  input  logic [9:0]                 DrawY,
  input  logic                       blank_n,
  input  logic                       frame_start,
  input  logic                       start,
  input  logic                       pause,
  input  logic                       restart,
  input  logic [3:0]                 speed,
  output logic [ADDR_W-1:0]          rom_addr,
  input  logic [3:0]                 rom_q,
  output logic [3:0]                 index,
  output logic [BG_W_LOG2+SHIFT-1:0] scroll_x,
  output logic [1:0]                 state
);

  // Scroll offset width in screen pixels. The wrap modulus is 2^SW.
  localparam int SW      = BG_W_LOG2 + SHIFT;
  // Width of the full row/column concatenation before truncation to ADDR_W.
  localparam int AFULL_W = 10 + BG_W_LOG2;

  localparam logic [1:0] ST_IDLE   = 2'b00;
  localparam logic [1:0] ST_RUN    = 2'b01;
  localparam logic [1:0] ST_FREEZE = 2'b10;

  localparam logic [3:0] LP_BLANK = 4'(BLANK_IDX);
  localparam logic [9:0] LP_BG_H  = 10'(BG_H);

  logic [1:0]           r_state;
  logic [1:0]           w_state_nxt;
  logic [SW-1:0]        r_scroll;
  logic [ADDR_W-1:0]    r_rom_addr;
  logic                 r_force1;
  logic                 r_force2;
  logic [3:0]           r_index;

  logic [10:0]          w_sum;
  logic [SW-1:0]        w_sx;
  logic [BG_W_LOG2-1:0] w_u;
  logic [9:0]           w_v;
  logic [AFULL_W-1:0]   w_addr_full;
  logic                 w_force;
  logic                 w_advance;

  // Next scroll state.
  // Priority is restart, then pause, then start. A pause in IDLE or FREEZE
  // has nothing to do, but it still suppresses a coincident start.
  always_comb begin
    w_state_nxt = r_state;
    if (restart) begin
      w_state_nxt = ST_IDLE;
    end else if (pause) begin
      if (r_state == ST_RUN) w_state_nxt = ST_FREEZE;
    end else if (start) begin
      if (r_state == ST_IDLE || r_state == ST_FREEZE) w_state_nxt = ST_RUN;
    end
  end

  // Scroll advances once per frame, and only while running.
  // A pause on the frame_start cycle cancels that frame's step.
  assign w_advance = frame_start && (r_state == ST_RUN) && !pause;

  // Register the state and the scroll offset. restart clears the offset and
  // overrides a coincident frame_start.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_state  <= ST_IDLE;
      r_scroll <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (restart)        r_scroll <= '0;
      else if (w_advance) r_scroll <= r_scroll + {{(SW-4){1'b0}}, speed};
    end
  end

  // Stage 1 address math.
  // The sum is formed at 11 bits so no carry is lost. The wrap to 2^SW is
  // then a truncation.
  assign w_sum       = {1'b0, DrawX} + {{(11-SW){1'b0}}, r_scroll};
  assign w_sx        = w_sum[SW-1:0];
  assign w_u         = w_sx[SW-1:SHIFT];
  assign w_v         = DrawY >> SHIFT;
  assign w_addr_full = {w_v, w_u};
  assign w_force     = (w_v >= LP_BG_H) || !blank_n;

  // Stage 1: register the ROM address and the force-blank flag.
  // Forced pixels fetch address 0 so the ROM port sees a quiet address.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_rom_addr <= '0;
      r_force1   <= 1'b0;
    end else begin
      r_rom_addr <= w_force ? '0 : w_addr_full[ADDR_W-1:0];
      r_force1   <= w_force;
    end
  end

  // Stage 2 delays the force flag to line up with the ROM data. Stage 3
  // then selects between the ROM data and the blank index.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_force2 <= 1'b0;
      r_index  <= LP_BLANK;
    end else begin
      r_force2 <= r_force1;
      r_index  <= r_force2 ? LP_BLANK : rom_q;
    end
  end

  assign rom_addr = r_rom_addr;
  assign index    = r_index;
  assign scroll_x = r_scroll;
  assign state    = r_state;

endmodule
